// File: rtl/edge_window_counter_pkg.sv
// rtl/edge_window_counter_pkg.sv - shared types and constants for the edge window counter
package freq_counter_pkg;

   localparam int CNT_W   = 7;
   localparam int DIGIT_W = 4;

   localparam logic [CNT_W-1:0] MAX_COUNT = 7'd99;

   typedef enum logic {
      IDLE,
      TENS
   } bcd_state_t;

endpackage

// File: rtl/edge_window_counter_if.sv
// rtl/edge_window_counter_if.sv - edge pulse input and published digit bundle
interface edge_window_counter_if;
   import freq_counter_pkg::*;

   logic               edge_pulse;
   logic [DIGIT_W-1:0] tens;
   logic [DIGIT_W-1:0] units;
   logic               overflow;
   logic               valid;

   modport master (
      output edge_pulse,
      input  tens,
      input  units,
      input  overflow,
      input  valid
   );

   modport slave (
      input  edge_pulse,
      output tens,
      output units,
      output overflow,
      output valid
   );

endinterface

// File: rtl/edge_window_counter_bcd2_serial.sv
// rtl/edge_window_counter_bcd2_serial.sv - serial two-digit binary-to-BCD by repeated subtraction of ten
module bcd2_serial
   import freq_counter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   value,
   input  logic               ovf_in,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] units,
   output logic               overflow,
   output logic               valid
);

   bcd_state_t         state, state_n;
   logic [CNT_W-1:0]   work, work_n;
   logic [DIGIT_W-1:0] tens_acc, tens_acc_n;
   logic               ovf_hold, ovf_hold_n;
   logic [DIGIT_W-1:0] tens_n, units_n;
   logic               overflow_n, valid_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         work     <= '0;
         tens_acc <= '0;
         ovf_hold <= 1'b0;
         tens     <= '0;
         units    <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         state    <= state_n;
         work     <= work_n;
         tens_acc <= tens_acc_n;
         ovf_hold <= ovf_hold_n;
         tens     <= tens_n;
         units    <= units_n;
         overflow <= overflow_n;
         valid    <= valid_n;
      end
   end

   always_comb begin
      state_n    = state;
      work_n     = work;
      tens_acc_n = tens_acc;
      ovf_hold_n = ovf_hold;
      tens_n     = tens;
      units_n    = units;
      overflow_n = overflow;
      valid_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n    = TENS;
               work_n     = value;
               ovf_hold_n = ovf_in;
               tens_acc_n = '0;
            end
         end
         TENS: begin
            if (work >= 7'd10) begin
               work_n     = work - 7'd10;
               tens_acc_n = tens_acc + 4'd1;
            end else begin
               // work < 10 here, so its low nibble is the units digit
               tens_n     = tens_acc;
               units_n    = work[DIGIT_W-1:0];
               overflow_n = ovf_hold;
               valid_n    = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // The window is long enough that a new result never arrives mid-conversion.
   a_no_start_in_tens: assert property (@(posedge clk) disable iff (reset)
      !(start && state == TENS));

endmodule

// File: rtl/edge_window_counter.sv
// rtl/edge_window_counter.sv - gapless fixed-window edge counter with saturating count and BCD output
module edge_window_counter
   import freq_counter_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1000,
   parameter int WIN_W         = $clog2(WINDOW_CYCLES)
)
(
   input  logic clk,
   input  logic reset,
   edge_window_counter_if.slave bus
);

   localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(WINDOW_CYCLES - 1);

   logic [WIN_W-1:0] win;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             win_end;
   logic             at_max;
   logic [CNT_W-1:0] cnt_final;
   logic             ovf_final;

   // A pulse in the window's last cycle still belongs to that window.
   always_comb begin
      win_end   = (win == '0);
      at_max    = (cnt == MAX_COUNT);
      cnt_final = (bus.edge_pulse && !at_max) ? cnt + 7'd1 : cnt;
      ovf_final = ovf | (bus.edge_pulse & at_max);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win <= WIN_RELOAD;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         win <= win_end ? WIN_RELOAD : win - WIN_W'(1);
         if (win_end) begin
            cnt <= '0;
            ovf <= 1'b0;
         end else begin
            cnt <= cnt_final;
            ovf <= ovf_final;
         end
      end
   end

   bcd2_serial u_bcd (
      .clk      (clk),
      .reset    (reset),
      .start    (win_end),
      .value    (cnt_final),
      .ovf_in   (ovf_final),
      .tens     (bus.tens),
      .units    (bus.units),
      .overflow (bus.overflow),
      .valid    (bus.valid)
   );

endmodule

// File: tb/tb_edge_window_counter.sv
// tb/tb_edge_window_counter.sv - directed self-checking bench for edge_window_counter
module tb_edge_window_counter;

   localparam int WC = 150;
   localparam int NEXP = 12;

   logic clk;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cyc;
   logic prev_v = 1'b0;

   int q_t[$];
   int q_u[$];
   int q_o[$];
   int q_c[$];

   int exp_t[NEXP];
   int exp_u[NEXP];
   int exp_o[NEXP];
   int exp_c[NEXP];

   edge_window_counter_if bus ();

   edge_window_counter #(.WINDOW_CYCLES(WC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.valid) begin
         chk("valid_single", {31'd0, prev_v}, 32'd0);
         q_t.push_back(int'(bus.tens));
         q_u.push_back(int'(bus.units));
         q_o.push_back(int'(bus.overflow));
         q_c.push_back(cyc);
      end
      prev_v = bus.valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pulse_fn(input int w, input int k);
      case (w)
         1:       return (k >= 10 && k < 47);
         2:       return (k == WC - 1);
         3:       return (k == 0);
         4:       return (k < 120);
         6:       return (k >= 50 && k < 73);
         7:       return (k < 85);
         0, 5:    return 1'b0;
         default: return (k % 15 == 0);
      endcase
   endfunction

   task automatic run_window(input int w);
      for (int k = 0; k < WC; k++) begin
         bus.edge_pulse = pulse_fn(w, k);
         tick();
      end
   endtask

   task automatic set_exp(input int i, input int t, input int u, input int o, input int c);
      exp_t[i] = t;
      exp_u[i] = u;
      exp_o[i] = o;
      exp_c[i] = c;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_tens"},  32'(bus.tens), 32'd0);
      chk({tag, "_units"}, 32'(bus.units), 32'd0);
      chk({tag, "_ovf"},   32'(bus.overflow), 32'd0);
      chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
   endtask

   initial begin
      // Strobe cycle = window end (150*(w+1)) + floor(count/10) + 1
      set_exp(0,  0, 0, 0,  151);
      set_exp(1,  3, 7, 0,  304);
      set_exp(2,  0, 1, 0,  451);
      set_exp(3,  0, 1, 0,  601);
      set_exp(4,  9, 9, 1,  760);
      set_exp(5,  0, 0, 0,  901);
      set_exp(6,  2, 3, 0, 1053);
      for (int j = 0; j < 5; j++) set_exp(7 + j, 1, 0, 0, WC * (j + 1) + 2);

      reset = 1'b1;
      bus.edge_pulse = 1'b0;
      repeat (3) begin
         tick();
         chk_outputs_zero("reset");
      end
      reset = 1'b0;

      for (int w = 0; w <= 7; w++) run_window(w);

      // Window 7 ends with 85 counted; reset lands while its conversion is running.
      repeat (3) begin
         bus.edge_pulse = 1'b1;
         tick();
      end
      reset = 1'b1;
      repeat (3) tick();
      chk_outputs_zero("midreset");
      reset = 1'b0;

      for (int w = 8; w <= 12; w++) run_window(w);
      bus.edge_pulse = 1'b0;
      repeat (15) tick();

      chk("hold_tens",  32'(bus.tens), 32'd1);
      chk("hold_units", 32'(bus.units), 32'd0);
      chk("hold_ovf",   32'(bus.overflow), 32'd0);
      chk("n_strobes",  32'(q_t.size()), 32'(NEXP));
      for (int i = 0; i < NEXP; i++) begin
         if (i < q_t.size()) begin
            chk($sformatf("tens[%0d]", i),  32'(q_t[i]), 32'(exp_t[i]));
            chk($sformatf("units[%0d]", i), 32'(q_u[i]), 32'(exp_u[i]));
            chk($sformatf("ovf[%0d]", i),   32'(q_o[i]), 32'(exp_o[i]));
            chk($sformatf("cyc[%0d]", i),   32'(q_c[i]), 32'(exp_c[i]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edge_window_counter.md
# edge_window_counter

Consumes the one-cycle leading-edge pulses produced by the edge detector and counts them over a fixed gate window of `WINDOW_CYCLES` clocks. At each window end it hands the saturated count to a sequential two-digit binary-to-BCD converter and publishes tens/units digits with a one-cycle `valid` strobe. The digit outputs feed the seven-segment display driver. Counting is gapless: the next window starts on the cycle after the previous one ends, while conversion of the previous result runs in parallel.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 1000: gate window length in clocks. Must be ≥ 16 so conversion finishes inside the next window.
- `WIN_W`, default `$clog2(WINDOW_CYCLES)`: width of the window down-counter.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `edge_pulse`  in  1  one-cycle pulse per input leading edge, from the edge detector.
- `tens`  out  4  published tens digit, 0–9.
- `units`  out  4  published units digit, 0–9.
- `overflow`  out  1  published with the digits; 1 = more than 99 edges in that window.
- `valid`  out  1  one-cycle strobe; the digits and `overflow` update in the same cycle.

## Operation
- Window counter `win`:
  - Loads `WINDOW_CYCLES-1` at reset.
  - Decrements each cycle.
  - When `win==0`, that cycle is the last cycle of the window, and `win` reloads on the next edge.
- Edge count `cnt` (7 bits):
  - Increments on `edge_pulse`.
  - Saturates at 99.
  - `edge_pulse` while `cnt==99` sets the sticky `ovf` bit.
- Window end (`win==0`):
  - A pulse in the last window cycle counts toward the ending window.
  - Final value = `cnt + edge_pulse`, saturated; `ovf` is updated the same way.
  - That final value loads `work`, and `ovf` loads `ovf_hold`.
  - `cnt` and `ovf` clear to 0 on the same edge.
  - A pulse in the first cycle of the new window counts toward the new window.
- Conversion FSM (states `IDLE`, `TENS`):
  - `IDLE`: at window end, go to `TENS`; `tens_acc` = 0.
  - `TENS` with `work ≥ 10`: `work -= 10`, `tens_acc += 1`.
  - `TENS` with `work < 10`:
    - `tens <= tens_acc`, `units <= work[3:0]`, `overflow <= ovf_hold`, `valid <= 1`.
    - Return to `IDLE`.
  - `valid` is otherwise 0.
- Arithmetic widths: `work` and `cnt` are 7 bits. `tens_acc` is 4 bits and never exceeds 9.
- Saturated result: reports tens = 9, units = 9, `overflow` = 1.
- Outputs hold their last published values between strobes.
- Reset, including mid-window or mid-conversion:
  - `win` = `WINDOW_CYCLES-1`; `cnt`, `ovf`, `work`, `tens_acc` = 0; FSM in `IDLE`.
  - `tens` = 0, `units` = 0, `overflow` = 0, `valid` = 0.
  - An in-progress conversion is discarded and never strobes.

## Timing
- Window length is exactly `WINDOW_CYCLES` clocks. The first window begins in the first cycle after `reset` deasserts.
- Let E0 be the clock edge that ends the window's last cycle, and N = floor(count/10).
- `valid` is high in the cycle after edge E(N+1).
  - Count 0–9: 1 cycle after E0.
  - Count 99: 10 cycles after E0.
- Worst-case conversion is 10 cycles, which is less than `WINDOW_CYCLES`. A new window end can therefore never arrive while the FSM is in `TENS`; this is asserted in simulation.
- `valid` is never high on two consecutive cycles.

## Structure
- Shared package `freq_counter_pkg` holds:
  - the FSM state enum (`IDLE`, `TENS`);
  - `MAX_COUNT = 99`;
  - `DIGIT_W = 4`;
  - `CNT_W = 7`.
- Sub-module `bcd2_serial` is the natural split. It contains:
  - the conversion FSM plus the `work` and `tens_acc` registers;
  - inputs: `clk`, `reset`, `start`, `value[6:0]`, `ovf_in`;
  - outputs: `tens`, `units`, `overflow`, `valid`.
- The top level holds the window counter, edge count and saturation logic.

## Test plan
- **Reset:** hold `reset` 3 cycles, with `WINDOW_CYCLES`=20 and no pulses → all outputs 0 during reset; first `valid` reports 0/0, overflow 0, 1 cycle after the first window end.
- **Digits and latency:** `WINDOW_CYCLES`=100, 37 pulses in one window → tens = 3, units = 7, overflow = 0; `valid` is a single cycle, 4 cycles after E0.
- **Window boundary:** pulse in the last cycle of window 1 and the first cycle of window 2, nothing else → window 1 reports 0/1 and window 2 reports 0/1.
- **Saturation:** `WINDOW_CYCLES`=150, pulse every cycle for 120 cycles → 9/9, overflow = 1, `valid` 10 cycles after E0; the next empty window reports 0/0 with overflow 0.
- **Reset mid-conversion:** 85 pulses, then assert `reset` 3 cycles after E0 → no `valid`; outputs 0; next window counts from 0.
- **Gapless streaming:** `WINDOW_CYCLES`=40, pulse every 4th cycle, free-running for 5 windows → every window reports 1/0 with no lost or double-counted pulses.
